read_ecc_check: RTL and testbench

- Read-direction counterpart of the page-program ECC path.
- Consumes the byte stream of a NAND page read (8 KB main data, then 192 B spare holding 64 x 3 B Hamming ECC) and recomputes ECC per 128 B chunk.
- Compares each recomputed code against the stored ECC and emits per-chunk correction records; the page-buffer owner applies the bit fixes.
- Reports page-level read_success/read_complete in the same encoding as the program path.

---
 rtl/nand_ecc_pkg.sv | 32 +++
 rtl/ecc_hamming_acc.sv | 19 +
 rtl/read_ecc_check.sv | 129 ++++++++++++
 tb/tb_read_ecc_check.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/nand_ecc_pkg.sv
// nand_ecc_pkg: shared NAND page ECC constants, encodings and per-byte Hamming contribution
package nand_ecc_pkg;
  localparam int CHUNK_LOG2 = 7;
  localparam int CHUNK_BYTES = 1 << CHUNK_LOG2;
  localparam int NUM_CHUNKS = 64;
  localparam int ECC_BYTES_PER_CHUNK = 3;
  localparam int SPARE_ECC_BYTES = NUM_CHUNKS * ECC_BYTES_PER_CHUNK;
  localparam logic [1:0] ST_CLEAN = 2'd0;
  localparam logic [1:0] ST_FIXED = 2'd1;
  localparam logic [1:0] ST_ECC_ERR = 2'd2;
  localparam logic [1:0] ST_UNCORR = 2'd3;
  localparam logic [1:0] RS_NONE = 2'd0;
  localparam logic [1:0] RS_OK = 2'd1;
  localparam logic [1:0] RS_FAIL = 2'd2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_SPARE = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  // Packed code {cp[5:0], rp[13:0]}; the always-zero rp[15:14]/cp[7:6] are not carried.
  function automatic logic [19:0] byte_ecc(input logic [6:0] a, input logic [7:0] d);
    logic [19:0] e;
    logic [2:0] bb;
    e = '0;
    for (int k = 0; k < 7; k++) e[2*k + int'(a[k])] = ^d;
    for (int k = 0; k < 3; k++)
      for (int b = 0; b < 8; b++) begin
        bb = 3'(b);
        e[14 + 2*k + int'(bb[k])] ^= d[b];
      end
    return e;
  endfunction
endpackage

// File: rtl/ecc_hamming_acc.sv
// ecc_hamming_acc: running rp/cp Hamming accumulator over a chunk, code includes the current byte
module ecc_hamming_acc
  import nand_ecc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [6:0]  addr,
  input  logic [7:0]  data,
  output logic [19:0] code
);
  logic [19:0] acc;
  assign code = acc ^ byte_ecc(addr, data);
  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else if (en) acc <= code;
  end
endmodule

// File: rtl/read_ecc_check.sv
// read_ecc_check: recomputes per-chunk Hamming ECC on a page read and reports correction records
module read_ecc_check
  import nand_ecc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] rd_data,
  input  logic       rd_valid,
  output logic       busy,
  output logic       fix_valid,
  output logic [5:0] fix_chunk,
  output logic [6:0] fix_byte,
  output logic [2:0] fix_bit,
  output logic [1:0] fix_status,
  output logic [1:0] read_success,
  output logic       read_complete,
  output logic [6:0] corr_count
);
  logic [1:0] state;
  logic [13:0] cnt;
  logic [1:0] t;
  logic [6:0] sch;
  logic [15:0] sh;
  logic [19:0] code_r;
  logic erased_r;
  logic cmp_v;
  logic [5:0] cmp_ch;
  logic [19:0] store [NUM_CHUNKS];
  logic [NUM_CHUNKS-1:0] all_ff;
  logic ff_run, any_unc;
  logic en, last, clr, single;
  logic [19:0] nxt, s;
  logic [23:0] code;
  logic [1:0] status;
  assign en = state == S_DATA && rd_valid;
  assign last = en && cnt[6:0] == 7'd127;
  assign clr = last || (state == S_IDLE && start);
  assign code = {rd_data, sh};
  ecc_hamming_acc u_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (en),
    .addr (cnt[6:0]),
    .data (rd_data),
    .code (nxt)
  );
  assign s = code_r ^ store[cmp_ch];
  // A single flipped data bit toggles exactly one half of every rp/cp pair.
  always_comb begin
    single = 1'b1;
    for (int k = 0; k < 10; k++) single &= s[2*k] ^ s[2*k+1];
  end
  assign status = (erased_r && all_ff[cmp_ch]) || s == '0 ? ST_CLEAN :
                  single ? ST_FIXED :
                  $countones(s) == 1 ? ST_ECC_ERR : ST_UNCORR;
  assign fix_valid = cmp_v;
  assign fix_chunk = cmp_v ? cmp_ch : '0;
  assign fix_status = cmp_v ? status : ST_CLEAN;
  assign fix_byte = cmp_v && status == ST_FIXED ? {s[13], s[11], s[9], s[7], s[5], s[3], s[1]} : '0;
  assign fix_bit = cmp_v && status == ST_FIXED ? {s[19], s[17], s[15]} : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy <= 1'b0;
      cnt <= '0;
      t <= '0;
      sch <= '0;
      sh <= '0;
      code_r <= '0;
      erased_r <= 1'b0;
      cmp_v <= 1'b0;
      cmp_ch <= '0;
      for (int i = 0; i < NUM_CHUNKS; i++) store[i] <= '0;
      all_ff <= '0;
      ff_run <= 1'b0;
      any_unc <= 1'b0;
      read_success <= RS_NONE;
      read_complete <= 1'b0;
      corr_count <= '0;
    end else begin
      cmp_v <= 1'b0;
      if (state == S_IDLE && start) begin
        state <= S_DATA;
        busy <= 1'b1;
        cnt <= '0;
        t <= '0;
        sch <= '0;
        ff_run <= 1'b1;
        any_unc <= 1'b0;
        read_success <= RS_NONE;
        read_complete <= 1'b0;
        corr_count <= '0;
      end
      if (en) begin
        cnt <= cnt == 14'd8191 ? '0 : cnt + 14'd1;
        ff_run <= last | (ff_run & rd_data == 8'hFF);
        if (last) begin
          store[cnt[12:7]] <= nxt;
          all_ff[cnt[12:7]] <= ff_run & rd_data == 8'hFF;
        end
        if (cnt == 14'd8191) state <= S_SPARE;
      end
      if (state == S_SPARE && rd_valid && !sch[6]) begin
        sh <= code[23:8];
        t <= t == 2'd2 ? 2'd0 : t + 2'd1;
        if (t == 2'd2) begin
          code_r <= {code[21:16], code[13:0]};
          erased_r <= code == 24'hFFFFFF;
          cmp_v <= 1'b1;
          cmp_ch <= sch[5:0];
          sch <= sch + 7'd1;
        end
      end
      if (cmp_v) begin
        if ((status == ST_FIXED || status == ST_ECC_ERR) && corr_count < 7'd64) corr_count <= corr_count + 7'd1;
        if (status == ST_UNCORR) any_unc <= 1'b1;
        if (cmp_ch == 6'd63) state <= S_DONE;
      end
      if (state == S_DONE) begin
        read_complete <= 1'b1;
        read_success <= any_unc ? RS_FAIL : RS_OK;
        busy <= 1'b0;
        state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_read_ecc_check.sv
// tb_read_ecc_check: table-driven page scenarios plus hand-written reset/abort sequences
module tb_read_ecc_check;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, rd_valid = 1'b0;
  logic [7:0] rd_data = '0;
  logic busy, fix_valid, read_complete;
  logic [5:0] fix_chunk;
  logic [6:0] fix_byte, corr_count;
  logic [2:0] fix_bit;
  logic [1:0] fix_status, read_success;
  int n_checks = 0, n_fail = 0, n_rec = 0;
  int rec_ch [1024], rec_st [1024], rec_byte [1024], rec_bit [1024];
  logic [7:0] pg [8384];
  typedef struct {
    int kind;
    int ch;
    int a1, b1, a2, b2;
    bit gaps;
    int exp_st, exp_byte, exp_bit, exp_rs, exp_corr;
  } vec_t;
  vec_t vt [7];

  always #5 clk = ~clk;

  read_ecc_check dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .busy          (busy),
    .fix_valid     (fix_valid),
    .fix_chunk     (fix_chunk),
    .fix_byte      (fix_byte),
    .fix_bit       (fix_bit),
    .fix_status    (fix_status),
    .read_success  (read_success),
    .read_complete (read_complete),
    .corr_count    (corr_count)
  );

  always @(negedge clk) begin
    if (fix_valid) begin
      if (n_rec < 1024) begin
        rec_ch[n_rec] = fix_chunk;
        rec_st[n_rec] = fix_status;
        rec_byte[n_rec] = fix_byte;
        rec_bit[n_rec] = fix_bit;
      end
      n_rec++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Bit-level reference: each set bit toggles one half of every rp and cp pair.
  task automatic gen_ecc();
    logic [15:0] rp;
    logic [7:0] cp;
    for (int c = 0; c < 64; c++) begin
      rp = '0;
      cp = '0;
      for (int a = 0; a < 128; a++)
        for (int b = 0; b < 8; b++)
          if (pg[c*128 + a][b]) begin
            for (int k = 0; k < 7; k++) rp[2*k + ((a >> k) & 1)] ^= 1'b1;
            for (int k = 0; k < 3; k++) cp[2*k + ((b >> k) & 1)] ^= 1'b1;
          end
      pg[8192 + 3*c] = rp[7:0];
      pg[8192 + 3*c + 1] = rp[15:8];
      pg[8192 + 3*c + 2] = cp;
    end
  endtask

  task automatic put(input logic [7:0] d, input bit g);
    if (g && $urandom_range(1) == 1) begin
      @(negedge clk);
      rd_valid = 1'b0;
    end
    @(negedge clk);
    rd_valid = 1'b1;
    rd_data = d;
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int base, ec;
    v = vt[vi];
    for (int i = 0; i < 8192; i++) pg[i] = v.kind == 4 ? 8'hFF : 8'($urandom);
    if (v.kind == 4) for (int i = 8192; i < 8384; i++) pg[i] = 8'hFF;
    else gen_ecc();
    if (v.kind == 1 || v.kind == 3) pg[v.ch*128 + v.a1][v.b1] ^= 1'b1;
    if (v.kind == 3) pg[v.ch*128 + v.a2][v.b2] ^= 1'b1;
    if (v.kind == 2) pg[8192 + 3*v.ch + v.a1][v.b1] ^= 1'b1;
    for (int i = 0; i < 3; i++) put(8'($urandom), 1'b0);
    @(negedge clk);
    rd_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base = n_rec;
    chk($sformatf("v%0d busy after start", vi), busy, 1);
    chk($sformatf("v%0d complete cleared", vi), read_complete, 0);
    for (int i = 0; i < 8384; i++) begin
      put(pg[i], v.gaps);
      start = i == 500;
    end
    @(negedge clk);
    rd_valid = 1'b0;
    start = 1'b0;
    for (int w = 0; w < 40 && read_complete !== 1'b1; w++) @(negedge clk);
    chk($sformatf("v%0d read_complete", vi), read_complete, 1);
    chk($sformatf("v%0d record count", vi), n_rec - base, 64);
    for (int j = 0; j < 64 && base + j < 1024; j++) begin
      ec = j == v.ch && v.kind >= 1 && v.kind <= 3;
      chk($sformatf("v%0d rec%0d chunk", vi, j), rec_ch[base+j], j);
      chk($sformatf("v%0d rec%0d status", vi, j), rec_st[base+j], ec ? v.exp_st : 0);
      chk($sformatf("v%0d rec%0d byte", vi, j), rec_byte[base+j], ec ? v.exp_byte : 0);
      chk($sformatf("v%0d rec%0d bit", vi, j), rec_bit[base+j], ec ? v.exp_bit : 0);
    end
    chk($sformatf("v%0d read_success", vi), read_success, v.exp_rs);
    chk($sformatf("v%0d corr_count", vi), corr_count, v.exp_corr);
    chk($sformatf("v%0d busy at end", vi), busy, 0);
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d complete holds", vi), read_complete, 1);
    chk($sformatf("v%0d success holds", vi), read_success, v.exp_rs);
  endtask

  initial begin
    vt[0] = '{0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 1, 0};
    vt[1] = '{1, 0, 2, 0, 0, 0, 1'b0, 1, 2, 0, 1, 1};
    vt[2] = '{1, 63, 127, 7, 0, 0, 1'b0, 1, 127, 7, 1, 1};
    vt[3] = '{2, 10, 0, 3, 0, 0, 1'b0, 2, 0, 0, 1, 1};
    vt[4] = '{3, 5, 3, 1, 70, 6, 1'b0, 3, 0, 0, 2, 0};
    vt[5] = '{4, 0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 1, 0};
    vt[6] = '{1, 20, 45, 5, 0, 0, 1'b1, 1, 45, 5, 1, 1};
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset fix_valid", fix_valid, 0);
    chk("reset read_success", read_success, 0);
    chk("reset read_complete", read_complete, 0);
    chk("reset corr_count", corr_count, 0);
    rst = 1'b0;
    run_vec(0);
    run_vec(1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int base;
      base = n_rec;
      for (int i = 0; i < 1000; i++) put(8'($urandom), 1'b0);
      @(negedge clk);
      rst = 1'b1;
      rd_valid = 1'b0;
      @(negedge clk);
      chk("abort busy", busy, 0);
      chk("abort fix_valid", fix_valid, 0);
      chk("abort read_success", read_success, 0);
      chk("abort read_complete", read_complete, 0);
      chk("abort corr_count", corr_count, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort no records", n_rec - base, 0);
    end
    for (int i = 2; i < 7; i++) run_vec(i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
